// File: rtl/msh_wr_sched_if.sv
// Write-scheduler bundle: ingress request lanes in, per-bank memory write strobes out.
// The scheduler sits on the slave side of this bundle.
interface msh_wr_sched_if #(
   parameter int NUM_PORTS = 4,
   parameter int NUM_BANKS = 4,
   parameter int ROW_W     = 10,
   parameter int DATA_W    = 64,
   parameter int BANK_W    = $clog2(NUM_BANKS),
   parameter int PORT_W    = $clog2(NUM_PORTS)
);
   logic [NUM_PORTS-1:0]             in_vld;
   logic [NUM_PORTS-1:0]             in_rdy;
   logic [NUM_PORTS-1:0][BANK_W-1:0] in_bank;
   logic [NUM_PORTS-1:0][ROW_W-1:0]  in_row;
   logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;
   logic [NUM_BANKS-1:0]             bank_wr_en;
   logic [NUM_BANKS-1:0][ROW_W-1:0]  bank_wr_row;
   logic [NUM_BANKS-1:0][DATA_W-1:0] bank_wr_data;
   logic [NUM_BANKS-1:0][PORT_W-1:0] bank_wr_port;
   logic [15:0]                      conflict_cnt;

   modport master (
      output in_vld, in_bank, in_row, in_data,
      input  in_rdy, bank_wr_en, bank_wr_row, bank_wr_data, bank_wr_port, conflict_cnt
   );

   modport slave (
      input  in_vld, in_bank, in_row, in_data,
      output in_rdy, bank_wr_en, bank_wr_row, bank_wr_data, bank_wr_port, conflict_cnt
   );
endinterface

// File: rtl/msh_wr_sched.sv
// Per-port FIFOs feeding per-bank round-robin arbiters; push-to-strobe latency 2 cycles.
// Ingress backpressured by registered in_rdy (no bypass); bank side never stalls.
module msh_wr_sched #(
   parameter int NUM_PORTS  = 4,
   parameter int NUM_BANKS  = 4,
   parameter int ROW_W      = 10,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          mclk,
   input  logic          mrst_n,
   msh_wr_sched_if.slave io
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int PORT_W = $clog2(NUM_PORTS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LOSS_W = $clog2(NUM_PORTS + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t              mem [NUM_PORTS][FIFO_DEPTH];
   req_t              head [NUM_PORTS];
   logic [PTR_W-1:0]  wptr [NUM_PORTS];
   logic [PTR_W-1:0]  rptr [NUM_PORTS];
   logic [CNT_W-1:0]  cnt [NUM_PORTS];
   logic [CNT_W-1:0]  cnt_nxt [NUM_PORTS];
   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] head_vld;
   logic [PORT_W-1:0] rr_ptr [NUM_BANKS];
   logic [PORT_W-1:0] gnt_port [NUM_BANKS];
   logic [NUM_BANKS-1:0] gnt_vld;
   logic [LOSS_W-1:0] loss;
   logic [16:0]       conf_sum;

   function automatic logic [PORT_W-1:0] rr_idx(input logic [PORT_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return PORT_W'(s);
   endfunction

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         head[p]     = mem[p][rptr[p]];
         head_vld[p] = (cnt[p] != '0);
         push[p]     = io.in_vld[p] & io.in_rdy[p];
      end
   end

   // Scan offsets from high to low so the last hit is the first candidate at or after rr_ptr.
   always_comb begin
      pop     = '0;
      gnt_vld = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_port[b] = rr_ptr[b];
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (head_vld[rr_idx(rr_ptr[b], i)] &&
                head[rr_idx(rr_ptr[b], i)].bank == BANK_W'(b)) begin
               gnt_vld[b]  = 1'b1;
               gnt_port[b] = rr_idx(rr_ptr[b], i);
            end
         end
         if (gnt_vld[b]) pop[gnt_port[b]] = 1'b1;
      end
   end

   always_comb begin
      loss = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         loss       = loss + LOSS_W'(head_vld[p] & ~pop[p]);
         cnt_nxt[p] = cnt[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
      conf_sum = {1'b0, io.conflict_cnt} + 17'(loss);
   end

   // Storage is deliberately unreset; count/pointers alone define what is valid.
   always_ff @(posedge mclk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (push[p]) mem[p][wptr[p]] <= '{bank: io.in_bank[p], row: io.in_row[p], data: io.in_data[p]};
      end
   end

   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wptr[p] <= '0;
            rptr[p] <= '0;
            cnt[p]  <= '0;
         end
         for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
         io.in_rdy       <= '0;
         io.bank_wr_en   <= '0;
         io.bank_wr_row  <= '0;
         io.bank_wr_data <= '0;
         io.bank_wr_port <= '0;
         io.conflict_cnt <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) wptr[p] <= wptr[p] + 1'b1;
            if (pop[p])  rptr[p] <= rptr[p] + 1'b1;
            cnt[p]       <= cnt_nxt[p];
            io.in_rdy[p] <= (cnt_nxt[p] < DEPTH_C);
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_vld[b]) begin
               rr_ptr[b]          <= rr_idx(gnt_port[b], 1);
               io.bank_wr_row[b]  <= head[gnt_port[b]].row;
               io.bank_wr_data[b] <= head[gnt_port[b]].data;
               io.bank_wr_port[b] <= gnt_port[b];
            end
         end
         io.bank_wr_en   <= gnt_vld;
         io.conflict_cnt <= conf_sum[16] ? 16'hFFFF : conf_sum[15:0];
      end
   end
endmodule

// File: tb/tb_msh_wr_sched.sv
// Directed bench for msh_wr_sched: reset, single write, contention, parallel banks,
// backpressure, streaming wrap and mid-operation reset.
module tb_msh_wr_sched;
   localparam int NP = 4;
   localparam int NB = 4;
   localparam int RW = 10;
   localparam int DW = 64;
   localparam int FD = 4;

   logic mclk   = 1'b0;
   logic mrst_n = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   always #5 mclk = ~mclk;

   msh_wr_sched_if #(.NUM_PORTS(NP), .NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW)) io();

   msh_wr_sched #(
      .NUM_PORTS(NP), .NUM_BANKS(NB), .ROW_W(RW), .DATA_W(DW), .FIFO_DEPTH(FD)
   ) dut (
      .mclk  (mclk),
      .mrst_n(mrst_n),
      .io    (io)
   );

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic idle_inputs();
      io.in_vld  = '0;
      io.in_bank = '0;
      io.in_row  = '0;
      io.in_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      mrst_n = 1'b0;
      repeat (2) step();
      mrst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      mrst_n = 1'b0;
      step();
      step();
      total++; if (io.in_rdy !== 4'h0) begin bad++; $display("FAIL reset_in_rdy got=%h want=0", io.in_rdy); end
      total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL reset_wr_en got=%h want=0", io.bank_wr_en); end
      total++; if (io.conflict_cnt !== 16'h0) begin bad++; $display("FAIL reset_conflict got=%h want=0", io.conflict_cnt); end
      total++; if (io.bank_wr_row !== '0 || io.bank_wr_port !== '0 || io.bank_wr_data !== '0) begin
         bad++; $display("FAIL reset_wr_bus row=%h port=%h want=0", io.bank_wr_row, io.bank_wr_port);
      end
      mrst_n = 1'b1;
      #1;
      total++; if (io.in_rdy !== 4'h0) begin bad++; $display("FAIL release_rdy_early got=%h want=0", io.in_rdy); end
      step();
      total++; if (io.in_rdy !== 4'hF) begin bad++; $display("FAIL release_rdy got=%h want=f", io.in_rdy); end
   endtask

   task automatic test_single();
      do_reset();
      io.in_vld     = 4'b0001;
      io.in_bank[0] = 2'd2;
      io.in_row[0]  = 10'h005;
      io.in_data[0] = 64'hA5A5;
      step();
      idle_inputs();
      total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL single_early got=%b want=0000", io.bank_wr_en); end
      step();
      total++; if (io.bank_wr_en !== 4'b0100) begin bad++; $display("FAIL single_en got=%b want=0100", io.bank_wr_en); end
      total++; if (io.bank_wr_row[2] !== 10'h005) begin bad++; $display("FAIL single_row got=%h want=005", io.bank_wr_row[2]); end
      total++; if (io.bank_wr_data[2] !== 64'hA5A5) begin bad++; $display("FAIL single_data got=%h want=a5a5", io.bank_wr_data[2]); end
      total++; if (io.bank_wr_port[2] !== 2'd0) begin bad++; $display("FAIL single_port got=%0d want=0", io.bank_wr_port[2]); end
      total++; if (io.conflict_cnt !== 16'd0) begin bad++; $display("FAIL single_conflict got=%0d want=0", io.conflict_cnt); end
      step();
      total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL single_en_drop got=%b want=0000", io.bank_wr_en); end
      total++; if (io.bank_wr_row[2] !== 10'h005) begin bad++; $display("FAIL single_row_hold got=%h want=005", io.bank_wr_row[2]); end
   endtask

   task automatic test_contention();
      do_reset();
      io.in_vld = 4'hF;
      for (int p = 0; p < NP; p++) begin
         io.in_bank[p] = 2'd1;
         io.in_row[p]  = 10'(16 + p);
         io.in_data[p] = 64'(100 + p);
      end
      step();
      idle_inputs();
      for (int k = 0; k < NP; k++) begin
         step();
         total++; if (io.bank_wr_en !== 4'b0010) begin bad++; $display("FAIL contend_en[%0d] got=%b want=0010", k, io.bank_wr_en); end
         total++; if (io.bank_wr_port[1] !== 2'(k)) begin bad++; $display("FAIL contend_port[%0d] got=%0d want=%0d", k, io.bank_wr_port[1], k); end
         total++; if (io.bank_wr_row[1] !== 10'(16 + k)) begin bad++; $display("FAIL contend_row[%0d] got=%0d want=%0d", k, io.bank_wr_row[1], 16 + k); end
      end
      total++; if (io.conflict_cnt !== 16'd6) begin bad++; $display("FAIL contend_conflict got=%0d want=6", io.conflict_cnt); end
      step();
      total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL contend_drain got=%b want=0000", io.bank_wr_en); end
   endtask

   task automatic test_parallel();
      do_reset();
      io.in_vld = 4'hF;
      for (int p = 0; p < NP; p++) begin
         io.in_bank[p] = 2'(3 - p);
         io.in_row[p]  = 10'(32 + p);
      end
      step();
      idle_inputs();
      step();
      total++; if (io.bank_wr_en !== 4'hF) begin bad++; $display("FAIL parallel_en got=%b want=1111", io.bank_wr_en); end
      for (int b = 0; b < NB; b++) begin
         total++; if (io.bank_wr_port[b] !== 2'(3 - b)) begin bad++; $display("FAIL parallel_port[%0d] got=%0d want=%0d", b, io.bank_wr_port[b], 3 - b); end
         total++; if (io.bank_wr_row[b] !== 10'(35 - b)) begin bad++; $display("FAIL parallel_row[%0d] got=%0d want=%0d", b, io.bank_wr_row[b], 35 - b); end
      end
      total++; if (io.conflict_cnt !== 16'd0) begin bad++; $display("FAIL parallel_conflict got=%0d want=0", io.conflict_cnt); end
   endtask

   // Port 0 offers 12 writes, port 1 streams endlessly, all to bank 0. Grants alternate
   // 0,1,0,1 so port 0 nets +1 entry every two cycles and fills on its 7th accept.
   task automatic test_backpressure();
      int p0_n, p1_n, p0_w, p1_w, nw, first_low;
      logic [NP-1:0] rdy_s, vld_s;
      logic [1:0] exp_port;
      do_reset();
      p0_n = 0; p1_n = 0; p0_w = 0; p1_w = 0; nw = 0; first_low = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         io.in_vld     = {2'b00, 1'b1, (p0_n < 12)};
         io.in_bank[0] = 2'd0;
         io.in_bank[1] = 2'd0;
         io.in_row[0]  = 10'(p0_n);
         io.in_row[1]  = 10'(256 + p1_n);
         rdy_s = io.in_rdy;
         vld_s = io.in_vld;
         step();
         if (vld_s[0] & rdy_s[0]) p0_n++;
         if (vld_s[1] & rdy_s[1]) p1_n++;
         if (!io.in_rdy[0] && first_low < 0) first_low = p0_n;
         total++; if ((io.bank_wr_en & 4'b1110) !== 4'h0) begin bad++; $display("FAIL bp_stray_bank cyc=%0d got=%b", cyc, io.bank_wr_en); end
         if (io.bank_wr_en[0]) begin
            exp_port = (p0_w < 12 && (nw % 2) == 0) ? 2'd0 : 2'd1;
            total++; if (io.bank_wr_port[0] !== exp_port) begin bad++; $display("FAIL bp_port w=%0d got=%0d want=%0d", nw, io.bank_wr_port[0], exp_port); end
            if (io.bank_wr_port[0] == 2'd0) begin
               total++; if (io.bank_wr_row[0] !== 10'(p0_w)) begin bad++; $display("FAIL bp_row_p0 got=%0d want=%0d", io.bank_wr_row[0], p0_w); end
               p0_w++;
            end else begin
               total++; if (io.bank_wr_row[0] !== 10'(256 + p1_w)) begin bad++; $display("FAIL bp_row_p1 got=%0d want=%0d", io.bank_wr_row[0], 256 + p1_w); end
               p1_w++;
            end
            nw++;
         end
      end
      idle_inputs();
      total++; if (first_low !== 7) begin bad++; $display("FAIL bp_rdy_fall accepts=%0d want=7", first_low); end
      total++; if (p0_n !== 12 || p0_w !== 12) begin bad++; $display("FAIL bp_p0_total accepted=%0d written=%0d want=12", p0_n, p0_w); end
      total++; if (p1_w > p1_n) begin bad++; $display("FAIL bp_p1_dup written=%0d accepted=%0d", p1_w, p1_n); end
   endtask

   task automatic test_wrap();
      int n;
      logic [NP-1:0] rdy_s, vld_s;
      logic [3:0] exp_en;
      do_reset();
      n = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         idle_inputs();
         if (n < 20) begin
            io.in_vld[2]  = 1'b1;
            io.in_bank[2] = 2'(n % 4);
            io.in_row[2]  = 10'(64 + n);
            io.in_data[2] = 64'(n * 3);
            total++; if (io.in_rdy[2] !== 1'b1) begin bad++; $display("FAIL wrap_rdy n=%0d got=%b want=1", n, io.in_rdy[2]); end
         end
         rdy_s = io.in_rdy;
         vld_s = io.in_vld;
         step();
         if (vld_s[2] & rdy_s[2]) n++;
         exp_en = (cyc >= 1 && cyc <= 20) ? 4'(1 << ((cyc - 1) % 4)) : 4'h0;
         total++; if (io.bank_wr_en !== exp_en) begin bad++; $display("FAIL wrap_en cyc=%0d got=%b want=%b", cyc, io.bank_wr_en, exp_en); end
         if (cyc >= 1 && cyc <= 20) begin
            total++; if (io.bank_wr_row[(cyc - 1) % 4] !== 10'(64 + cyc - 1) || io.bank_wr_port[(cyc - 1) % 4] !== 2'd2 ||
                         io.bank_wr_data[(cyc - 1) % 4] !== 64'((cyc - 1) * 3)) begin
               bad++; $display("FAIL wrap_write w=%0d row=%0d port=%0d want row=%0d port=2", cyc - 1,
                               io.bank_wr_row[(cyc - 1) % 4], io.bank_wr_port[(cyc - 1) % 4], 64 + cyc - 1);
            end
         end
      end
      idle_inputs();
      total++; if (n !== 20) begin bad++; $display("FAIL wrap_accepts got=%0d want=20", n); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      io.in_vld = 4'hF;
      for (int p = 0; p < NP; p++) begin
         io.in_bank[p] = 2'd3;
         io.in_row[p]  = 10'(48 + p);
      end
      step();
      idle_inputs();
      step();
      total++; if (io.bank_wr_en !== 4'b1000) begin bad++; $display("FAIL rmid_pre_en got=%b want=1000", io.bank_wr_en); end
      #2;
      mrst_n = 1'b0;
      #1;
      total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL rmid_async_en got=%b want=0000", io.bank_wr_en); end
      total++; if (io.in_rdy !== 4'h0) begin bad++; $display("FAIL rmid_rdy got=%h want=0", io.in_rdy); end
      total++; if (io.conflict_cnt !== 16'd0) begin bad++; $display("FAIL rmid_conflict got=%0d want=0", io.conflict_cnt); end
      step();
      step();
      mrst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (io.bank_wr_en !== 4'h0) begin bad++; $display("FAIL rmid_ghost k=%0d got=%b want=0000", k, io.bank_wr_en); end
      end
      io.in_vld[3]  = 1'b1;
      io.in_bank[3] = 2'd1;
      io.in_row[3]  = 10'h03F;
      step();
      idle_inputs();
      step();
      total++; if (io.bank_wr_en !== 4'b0010 || io.bank_wr_port[1] !== 2'd3 || io.bank_wr_row[1] !== 10'h03F) begin
         bad++; $display("FAIL rmid_after en=%b port=%0d row=%h want 0010/3/03f", io.bank_wr_en, io.bank_wr_port[1], io.bank_wr_row[1]);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_contention();
      test_parallel();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
